axist_mc_patchkr: RTL and testbench
===================================

// Module: axist_mc_patchkr
// PURPOSE
//  Multi-channel parametrised AXI-ST pattern checker for the simplex full examples; sits after the follower receive path.
//  Per channel: buffers expected beats in a sync FIFO, compares them against received beats, and counts errors (saturating).
//  Finishes on beat target, stop request or timeout. Reports 2-bit pass/fail plus first-error capture.
// PARAMETERS
//  NUM_CH      2    independent channels (1..8)
//  DATA_W      256  beat width per channel
//  CMP_W       40   low bits compared per beat (1..DATA_W)
//  FIFO_AW     9    expected-FIFO address width (depth 2**FIFO_AW)
//  ERR_W       16   error-counter width
//  TIMEOUT     1024 idle RUN cycles before forced DONE (0 = disabled)
// PORTS
//  rdclk        in   1              clock, all logic
//  rst_n        in   1              reset, synchronous, active-low
//  start        in   1              pulse: clear counters, enter RUN
//  stop         in   1              pulse: end continuous run
//  cont_mode    in   1              1 = ignore beat_target and run until stop
//  beat_target  in   16             beats per channel to check (sampled at start)
//  exp_valid    in   NUM_CH         expected-data push, per channel
//  exp_data     in   NUM_CH*DATA_W  expected beats; ch k = [k*DATA_W +: DATA_W]
//  exp_ready    out  NUM_CH         ~exp FIFO full
//  rx_valid     in   NUM_CH         received beat valid
//  rx_data      in   NUM_CH*DATA_W  received beats
//  rx_ready     out  NUM_CH         accept received beat
//  err_count    out  NUM_CH*ERR_W   per-channel mismatch count
//  first_err_ch out  3              channel of first mismatch
//  first_err_bt out  16             beat index of first mismatch
//  timeout_flag out  1              run ended by TIMEOUT
//  patchkr_out  out  2              00 idle/busy, 11 pass, 10 fail
// BEHAVIOUR
//  Reset: FSM IDLE, FIFOs empty, all counters/flags 0, patchkr_out 00, rx_ready 0, exp_ready 1.
//  FSM states:
//   - IDLE -> RUN on start.
//   - RUN -> DONE on any of: (!cont_mode & every ch beat_cnt == beat_target); stop; idle_cnt == TIMEOUT.
//   - DONE -> RUN on start.
//  Precedence: start beats stop when both arrive in the same cycle.
//  Start: zeroes err_count, beat_cnt, idle_cnt, first_err_*, timeout_flag and patchkr_out; latches beat_target. Expected FIFOs are NOT flushed.
//  Expected FIFO: exp_valid & exp_ready pushes, in any state. Push while full is dropped (cannot occur under protocol).
//  rx_ready[k] = RUN & ~exp_empty[k] & (cont_mode | beat_cnt[k] != target). A beat with empty expected FIFO is stalled, never an error.
//  Accepted beat (rx_valid & rx_ready):
//   - pops the expected FIFO in the same cycle;
//   - compares rx vs expected head [CMP_W-1:0] combinationally;
//   - increments beat_cnt[k].
//  Mismatch: err_count[k]+1, saturating at all-ones. First mismatch of a run latches ch/beat (lowest ch wins on ties).
//  Mismatch -> err_count update latency: 1 cycle.
//  idle_cnt: clears on any accepted beat, otherwise increments in RUN. Reaching TIMEOUT sets timeout_flag.
//  patchkr_out is set one cycle after entering DONE:
//   - 11 if all err_count==0 & !timeout_flag;
//   - otherwise 10.
//   It holds until the next start.
//  beat_cnt 16-bit; cont_mode wraps it silently, err_count still saturates.
//  rst_n low mid-run: immediate return to reset state, FIFOs emptied.
// STRUCTURE
//  Shared package axist_pkg: FSM state enum {IDLE,RUN,DONE}; PATCHKR_PASS=2'b11, PATCHKR_FAIL=2'b10, PATCHKR_BUSY=2'b00.
//  Sub-module axist_patchkr_lane (generate x NUM_CH) contains:
//   - sync FIFO;
//   - comparator;
//   - beat/error counters.
//  Top holds the FSM, idle timer, first-error arbiter and result.
// TESTING
//  1 NUM_CH=2, target=8, 8 matching beats/ch -> patchkr_out=11 ~1 cycle after last beat, err_count=0.
//  2 ch1 beat 3 bit0 flipped -> err_count[1]=1, first_err_ch=1, first_err_bt=3, patchkr_out=10.
//  3 exp FIFO empty while rx_valid=1 -> rx_ready=0, no count change; fill FIFO -> beats accepted.
//  4 ERR_W=4, 20 mismatching beats cont_mode -> err_count sticks 15; stop -> 10.
//  5 TIMEOUT=16, target=8, send 5 beats then idle -> DONE after 16 cycles, timeout_flag=1, out 10.
//  6 rst_n low mid-run then start -> all counters 0, FIFOs empty, FSM RUN, out 00.

Source files
------------

// File: rtl/axist_pkg.sv
// Shared types for the multi-channel AXI-ST pattern checker:
// checker FSM states, result codes and the beat-index width.
package axist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] PATCHKR_BUSY = 2'b00;
    localparam logic [1:0] PATCHKR_PASS = 2'b11;
    localparam logic [1:0] PATCHKR_FAIL = 2'b10;

    localparam int BT_W = 16;

endpackage

// File: rtl/axist_patchkr_lane.sv
// One checker lane: expected-beat sync FIFO, comparator on the
// low CMP_W bits, beat counter and saturating error counter.
// Ports:
//   rdclk, rst_n            clock, sync active-low reset
//   clr                     zero beat/error counters (run start)
//   run, cont_mode, target  FSM status, mode and latched beat target
//   exp_valid/data/ready    expected-beat push side
//   rx_valid/data/ready     received-beat side
//   accept, mism            beat taken / beat taken and mismatched
//   at_target, beat_cnt     beat counter and its target compare
//   err_count               saturating mismatch count
module axist_patchkr_lane
    import axist_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int CMP_W   = 40,
    parameter int FIFO_AW = 9,
    parameter int ERR_W   = 16
) (
    input  logic              rdclk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              run,
    input  logic              cont_mode,
    input  logic [BT_W-1:0]   target,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_data,
    output logic              exp_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              accept,
    output logic              mism,
    output logic              at_target,
    output logic [BT_W-1:0]   beat_cnt,
    output logic [ERR_W-1:0]  err_count
);

    localparam int DEPTH = 1 << FIFO_AW;

    // Only the compared bits are ever looked at, so only they are stored.
    logic [CMP_W-1:0] mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic [CMP_W-1:0] head;

    generate
        if (CMP_W < DATA_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^{exp_data[DATA_W-1:CMP_W],
                                 rx_data[DATA_W-1:CMP_W]};
        end
    endgenerate

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    assign exp_ready = ~full;
    assign push      = exp_valid & ~full;
    assign head      = mem[rd_ptr[FIFO_AW-1:0]];

    assign at_target = (beat_cnt == target);
    // A beat is only taken when its expected word is already queued.
    assign rx_ready  = run & ~empty & (cont_mode | ~at_target);
    assign accept    = rx_valid & rx_ready;
    assign mism      = accept & (rx_data[CMP_W-1:0] != head);

    always_ff @(posedge rdclk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= exp_data[CMP_W-1:0];
        end
    end

    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            err_count <= '0;
        end else if (clr) begin
            beat_cnt  <= '0;
            err_count <= '0;
        end else begin
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (mism && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axist_mc_patchkr.sv
// Multi-channel AXI-ST pattern checker top: run FSM, idle timer,
// first-error arbiter and pass/fail result over NUM_CH lanes.
// Ports:
//   rdclk, rst_n              clock, sync active-low reset
//   start, stop, cont_mode    run control; beat_target per channel
//   exp_valid/data/ready      per-channel expected-beat push
//   rx_valid/data/ready       per-channel received beats
//   err_count                 per-channel saturating mismatch count
//   first_err_ch/_bt          channel and beat of first mismatch
//   timeout_flag, patchkr_out run ended by timeout / 00,11,10 result
module axist_mc_patchkr
    import axist_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 256,
    parameter int CMP_W   = 40,
    parameter int FIFO_AW = 9,
    parameter int ERR_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     rdclk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     cont_mode,
    input  logic [BT_W-1:0]          beat_target,
    input  logic [NUM_CH-1:0]        exp_valid,
    input  logic [NUM_CH*DATA_W-1:0] exp_data,
    output logic [NUM_CH-1:0]        exp_ready,
    input  logic [NUM_CH-1:0]        rx_valid,
    input  logic [NUM_CH*DATA_W-1:0] rx_data,
    output logic [NUM_CH-1:0]        rx_ready,
    output logic [NUM_CH*ERR_W-1:0]  err_count,
    output logic [2:0]               first_err_ch,
    output logic [BT_W-1:0]          first_err_bt,
    output logic                     timeout_flag,
    output logic [1:0]               patchkr_out
);

    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] TMO_V = IDLE_W'(TIMEOUT);

    state_t            state;
    logic [BT_W-1:0]   target_q;
    logic [IDLE_W-1:0] idle_cnt;
    logic              first_vld;
    logic              run;
    logic [NUM_CH-1:0] acc;
    logic [NUM_CH-1:0] mism;
    logic [NUM_CH-1:0] at_tgt;
    logic [BT_W-1:0]   bc [NUM_CH];
    logic              hit;
    logic [2:0]        hit_ch;
    logic [BT_W-1:0]   hit_bt;
    logic              tmo_hit;
    logic              tgt_done;

    assign run = (state == RUN);

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
            axist_patchkr_lane #(
                .DATA_W  (DATA_W),
                .CMP_W   (CMP_W),
                .FIFO_AW (FIFO_AW),
                .ERR_W   (ERR_W)
            ) u_lane (
                .rdclk     (rdclk),
                .rst_n     (rst_n),
                .clr       (start),
                .run       (run),
                .cont_mode (cont_mode),
                .target    (target_q),
                .exp_valid (exp_valid[k]),
                .exp_data  (exp_data[k*DATA_W +: DATA_W]),
                .exp_ready (exp_ready[k]),
                .rx_valid  (rx_valid[k]),
                .rx_data   (rx_data[k*DATA_W +: DATA_W]),
                .rx_ready  (rx_ready[k]),
                .accept    (acc[k]),
                .mism      (mism[k]),
                .at_target (at_tgt[k]),
                .beat_cnt  (bc[k]),
                .err_count (err_count[k*ERR_W +: ERR_W])
            );
        end
    endgenerate

    // Scan high-to-low so the lowest mismatching channel wins.
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        hit_bt = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mism[k]) begin
                hit    = 1'b1;
                hit_ch = 3'(k);
                hit_bt = bc[k];
            end
        end
    end

    assign tmo_hit  = (TIMEOUT != 0) && (idle_cnt == TMO_V);
    assign tgt_done = ~cont_mode & (&at_tgt);

    always_ff @(posedge rdclk) begin
        if (!rst_n) begin
            state        <= IDLE;
            target_q     <= '0;
            idle_cnt     <= '0;
            first_vld    <= 1'b0;
            first_err_ch <= '0;
            first_err_bt <= '0;
            timeout_flag <= 1'b0;
            patchkr_out  <= PATCHKR_BUSY;
        end else if (start) begin
            // Start wins over a same-cycle stop and restarts from any state.
            state        <= RUN;
            target_q     <= beat_target;
            idle_cnt     <= '0;
            first_vld    <= 1'b0;
            first_err_ch <= '0;
            first_err_bt <= '0;
            timeout_flag <= 1'b0;
            patchkr_out  <= PATCHKR_BUSY;
        end else begin
            unique case (state)
                IDLE: begin
                end
                RUN: begin
                    if (hit && !first_vld) begin
                        first_vld    <= 1'b1;
                        first_err_ch <= hit_ch;
                        first_err_bt <= hit_bt;
                    end
                    if (|acc) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    if (stop || tmo_hit || tgt_done) begin
                        state <= DONE;
                        if (tmo_hit) begin
                            timeout_flag <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Judged one cycle in, once the last error update landed.
                    if (patchkr_out == PATCHKR_BUSY) begin
                        if ((err_count == '0) && !timeout_flag) begin
                            patchkr_out <= PATCHKR_PASS;
                        end else begin
                            patchkr_out <= PATCHKR_FAIL;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axist_mc_patchkr.sv
// Self-checking bench for axist_mc_patchkr: scoreboard of expected
// beats per channel with a saturating error-count model.
module tb_axist_mc_patchkr;
    import axist_pkg::*;

    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 64;
    localparam int CMP_W   = 40;
    localparam int FIFO_AW = 4;
    localparam int ERR_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic                     rdclk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic                     stop;
    logic                     cont_mode;
    logic [15:0]              beat_target;
    logic [NUM_CH-1:0]        exp_valid;
    logic [NUM_CH*DATA_W-1:0] exp_data;
    logic [NUM_CH-1:0]        exp_ready;
    logic [NUM_CH-1:0]        rx_valid;
    logic [NUM_CH*DATA_W-1:0] rx_data;
    logic [NUM_CH-1:0]        rx_ready;
    logic [NUM_CH*ERR_W-1:0]  err_count;
    logic [2:0]               first_err_ch;
    logic [15:0]              first_err_bt;
    logic                     timeout_flag;
    logic [1:0]               patchkr_out;

    axist_mc_patchkr #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .CMP_W   (CMP_W),
        .FIFO_AW (FIFO_AW),
        .ERR_W   (ERR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .rdclk        (rdclk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .cont_mode    (cont_mode),
        .beat_target  (beat_target),
        .exp_valid    (exp_valid),
        .exp_data     (exp_data),
        .exp_ready    (exp_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .err_count    (err_count),
        .first_err_ch (first_err_ch),
        .first_err_bt (first_err_bt),
        .timeout_flag (timeout_flag),
        .patchkr_out  (patchkr_out)
    );

    always #5 rdclk = ~rdclk;

    int n_cmp = 0;
    int n_bad = 0;
    int seed  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int ch, input int i);
        logic [31:0] lo;
        lo = 32'(i) * 32'h9E37_79B1 ^ 32'(ch) * 32'h5555_0000 ^ 32'(seed);
        return {8'(8'hA0 + ch), 24'(i), lo};
    endfunction

    // Scoreboard: expected words queued on push, popped on accept.
    logic [CMP_W-1:0] sbq [NUM_CH][$];
    int               m_err [NUM_CH];
    bit               armed = 1'b0;

    always @(negedge rdclk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sbq[k].delete();
                m_err[k] = 0;
            end
            armed = 1'b1;
        end else begin
            if (armed) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    chk($sformatf("err%0d", k),
                        64'(err_count[k*ERR_W +: ERR_W]), 64'(m_err[k]));
                end
            end
            if (start) begin
                for (int k = 0; k < NUM_CH; k++) m_err[k] = 0;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (rx_valid[k] && rx_ready[k]) begin
                        chk($sformatf("sb_has%0d", k),
                            64'(sbq[k].size() != 0), 64'd1);
                        if (sbq[k].size() != 0) begin
                            logic [CMP_W-1:0] e;
                            e = sbq[k].pop_front();
                            if (rx_data[k*DATA_W +: CMP_W] != e &&
                                m_err[k] < ERR_MAX)
                                m_err[k]++;
                        end
                    end
                end
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (exp_valid[k] && exp_ready[k])
                    sbq[k].push_back(exp_data[k*DATA_W +: CMP_W]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rdclk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            exp_valid = 2'b11;
            exp_data  = {pat(1, i), pat(0, i)};
            tick(1);
        end
        exp_valid = 2'b00;
    endtask

    // bad_bt < 0 flips bit 0 of every beat on the channels in bad_m.
    task automatic rx_beats(input int n, input logic [1:0] bad_m,
                            input int bad_bt);
        logic [1:0]        pend;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        int                g;
        for (int i = 0; i < n; i++) begin
            d0 = pat(0, i);
            d1 = pat(1, i);
            if (bad_m[0] && (bad_bt < 0 || bad_bt == i)) d0[0] = ~d0[0];
            if (bad_m[1] && (bad_bt < 0 || bad_bt == i)) d1[0] = ~d1[0];
            rx_data  = {d1, d0};
            pend     = 2'b11;
            rx_valid = pend;
            g        = 0;
            while (pend != 2'b00 && g < 40) begin
                @(negedge rdclk);
                pend = pend & ~(rx_valid & rx_ready);
                tick(1);
                rx_valid = pend;
                g++;
            end
            chk($sformatf("rx_acc%0d", i), 64'(pend), 64'd0);
        end
        rx_valid = 2'b00;
    endtask

    task automatic wait_out(input int lim, output int cyc);
        cyc = 0;
        while (patchkr_out == 2'b00 && cyc < lim) begin
            tick(1);
            cyc++;
        end
        chk("done_seen", 64'(patchkr_out != 2'b00), 64'd1);
    endtask

    int c;

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        cont_mode   = 1'b0;
        beat_target = 16'd8;
        exp_valid   = '0;
        exp_data    = '0;
        rx_valid    = '0;
        rx_data     = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        chk("rst_out", 64'(patchkr_out), 64'(PATCHKR_BUSY));
        chk("rst_rxr", 64'(rx_ready), 64'd0);
        chk("rst_expr", 64'(exp_ready), 64'h3);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_tmo", 64'(timeout_flag), 64'd0);
        chk("rst_fch", 64'(first_err_ch), 64'd0);
        chk("rst_fbt", 64'(first_err_bt), 64'd0);

        // 1: clean run to target
        seed = 1;
        push_exp(8);
        pulse_start();
        rx_beats(8, 2'b00, -1);
        wait_out(10, c);
        chk("t1_out", 64'(patchkr_out), 64'(PATCHKR_PASS));
        chk("t1_lat", 64'(c <= 3), 64'd1);
        chk("t1_err", 64'(err_count), 64'd0);

        // 2: single bit flip on ch1 beat 3
        seed = 2;
        push_exp(8);
        pulse_start();
        rx_beats(8, 2'b10, 3);
        wait_out(10, c);
        chk("t2_out", 64'(patchkr_out), 64'(PATCHKR_FAIL));
        chk("t2_err1", 64'(err_count[ERR_W +: ERR_W]), 64'd1);
        chk("t2_err0", 64'(err_count[0 +: ERR_W]), 64'd0);
        chk("t2_fch", 64'(first_err_ch), 64'd1);
        chk("t2_fbt", 64'(first_err_bt), 64'd3);

        // 3: empty expected FIFO stalls instead of erroring
        seed = 3;
        beat_target = 16'd4;
        pulse_start();
        rx_data  = {pat(1, 0), pat(0, 0)};
        rx_valid = 2'b11;
        tick(5);
        chk("t3_stall", 64'(rx_ready), 64'd0);
        chk("t3_err", 64'(err_count), 64'd0);
        rx_valid = 2'b00;
        push_exp(4);
        chk("t3_rdy", 64'(rx_ready), 64'h3);
        rx_beats(4, 2'b00, -1);
        wait_out(10, c);
        chk("t3_out", 64'(patchkr_out), 64'(PATCHKR_PASS));

        // 4: continuous mode, error counters saturate
        seed = 4;
        cont_mode = 1'b1;
        pulse_start();
        for (int b = 0; b < 2; b++) begin
            push_exp(10);
            rx_beats(10, 2'b11, -1);
        end
        tick(1);
        chk("t4_sat0", 64'(err_count[0 +: ERR_W]), 64'(ERR_MAX));
        chk("t4_sat1", 64'(err_count[ERR_W +: ERR_W]), 64'(ERR_MAX));
        chk("t4_busy", 64'(patchkr_out), 64'(PATCHKR_BUSY));
        pulse_stop();
        wait_out(10, c);
        chk("t4_out", 64'(patchkr_out), 64'(PATCHKR_FAIL));
        chk("t4_tmo", 64'(timeout_flag), 64'd0);
        cont_mode = 1'b0;

        // 5: idle timeout short of target
        seed = 5;
        beat_target = 16'd8;
        pulse_start();
        push_exp(5);
        rx_beats(5, 2'b00, -1);
        wait_out(40, c);
        chk("t5_out", 64'(patchkr_out), 64'(PATCHKR_FAIL));
        chk("t5_tmo", 64'(timeout_flag), 64'd1);
        chk("t5_win", 64'(c >= TIMEOUT && c <= TIMEOUT + 4), 64'd1);
        chk("t5_err", 64'(err_count), 64'd0);

        // 6: reset mid-run empties FIFOs and counters
        seed = 6;
        pulse_start();
        push_exp(3);
        rx_beats(1, 2'b01, 0);
        tick(1);
        chk("t6_err0", 64'(err_count[0 +: ERR_W]), 64'd1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        chk("t6_out", 64'(patchkr_out), 64'(PATCHKR_BUSY));
        chk("t6_err", 64'(err_count), 64'd0);
        chk("t6_expr", 64'(exp_ready), 64'h3);
        chk("t6_rxr", 64'(rx_ready), 64'd0);
        pulse_start();
        chk("t6_empty", 64'(rx_ready), 64'd0);
        chk("t6_busy", 64'(patchkr_out), 64'(PATCHKR_BUSY));
        push_exp(1);
        chk("t6_run", 64'(rx_ready), 64'h3);
        rx_beats(1, 2'b00, -1);
        pulse_stop();
        wait_out(10, c);
        chk("t6_fin", 64'(patchkr_out), 64'(PATCHKR_PASS));
        chk("t6_err2", 64'(err_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
